// File: rtl/tinyrv_pkg.sv
// Shared definitions for the tinyrv memory arbiter: state encoding and
// the default abort limit for a memory access.
package tinyrv_pkg;

    // Arbiter states: idle, serving the fetch port, serving the load/store port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } arb_state_t;

    // Cycles an access may wait for mem_ready before it is aborted.
    localparam int TO_CYC_DEFAULT = 255;

endpackage

// File: rtl/tinyrv_mem_arb.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory
// port. Round-robin on contention, one access in flight, per-access timeout.
module tinyrv_mem_arb
    import tinyrv_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int TO_CYC = TO_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    output logic              if_err,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [3:0]        ls_wstrb,
    output logic [31:0]       ls_rdata,
    output logic              ls_ack,
    output logic              ls_err,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    // Counter value seen in the last permitted waiting cycle; the abort fires
    // in the cycle where the count would reach TO_CYC.
    localparam logic [7:0] CNT_LAST = 8'(TO_CYC - 1);

    arb_state_t        r_state, w_state_next;
    logic [7:0]        r_cnt, w_cnt_next;
    logic              r_last_ls, w_last_ls_next;
    logic              r_mem_we, w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [31:0]       r_mem_wdata, w_mem_wdata_next;
    logic [3:0]        r_mem_wstrb, w_mem_wstrb_next;
    logic              w_grant_ls;
    logic              w_grant_if;
    logic              w_timeout;

    // The access is live exactly while the FSM is out of IDLE.
    assign mem_req   = (r_state != ST_IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

    // State, counter, round-robin flag and latched access fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_last_ls   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_last_ls   <= w_last_ls_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_wstrb <= w_mem_wstrb_next;
        end
    end

    // Next-state, grant decision and same-cycle completion outputs.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_last_ls_next   = r_last_ls;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_wstrb_next = r_mem_wstrb;
        if_ack           = 1'b0;
        if_err           = 1'b0;
        if_rdata         = 32'd0;
        ls_ack           = 1'b0;
        ls_err           = 1'b0;
        ls_rdata         = 32'd0;
        // LSU wins unless fetch also asks and LSU was served last.
        w_grant_ls       = ls_req && (!if_req || !r_last_ls);
        w_grant_if       = if_req && !w_grant_ls;
        // mem_ready takes priority over the abort in the same cycle.
        w_timeout        = !mem_ready && (r_cnt == CNT_LAST);

        case (r_state)
            ST_IDLE: begin
                if (w_grant_ls) begin
                    w_state_next     = ST_BUSY_LS;
                    w_cnt_next       = 8'd0;
                    w_last_ls_next   = 1'b1;
                    w_mem_we_next    = ls_we;
                    w_mem_addr_next  = ls_addr;
                    w_mem_wdata_next = ls_wdata;
                    w_mem_wstrb_next = ls_wstrb;
                end else if (w_grant_if) begin
                    w_state_next     = ST_BUSY_IF;
                    w_cnt_next       = 8'd0;
                    w_last_ls_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                    w_mem_addr_next  = if_addr;
                    w_mem_wdata_next = 32'd0;
                    w_mem_wstrb_next = 4'd0;
                end
            end
            ST_BUSY_IF: begin
                if (mem_ready) begin
                    if_ack       = 1'b1;
                    if_rdata     = mem_rdata;
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    if_ack       = 1'b1;
                    if_err       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            ST_BUSY_LS: begin
                if (mem_ready) begin
                    ls_ack       = 1'b1;
                    ls_rdata     = r_mem_we ? 32'd0 : mem_rdata;
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    ls_ack       = 1'b1;
                    ls_err       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tinyrv_mem_arb.sv
// Self-checking bench for tinyrv_mem_arb: directed scenarios followed by
// random traffic, checked against a transaction-level model.
module tb_tinyrv_mem_arb;

    localparam int ADDR_W = 24;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              if_err;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [3:0]        ls_wstrb;
    logic [31:0]       ls_rdata;
    logic              ls_ack;
    logic              ls_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    int n_assert = 0;
    int n_fail   = 0;
    bit m_last_ls = 1'b0;   // model: who was served last
    int who;
    int prev_who;

    always #5 clk = ~clk;

    tinyrv_mem_arb #(.ADDR_W(ADDR_W), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_rdata(ls_rdata),
        .ls_ack(ls_ack), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = ADDR_W'($urandom) & {{(ADDR_W-2){1'b1}}, 2'b00};
    endtask

    task automatic new_ls();
        ls_req   = 1'b1;
        ls_we    = 1'($urandom);
        ls_addr  = ADDR_W'($urandom) | ADDR_W'(1);
        ls_wdata = $urandom;
        ls_wstrb = 4'($urandom);
    endtask

    // One access. Entered in an IDLE cycle (after a posedge) with requests
    // already driven; returns just after the edge that ends the access.
    // lat > TO means memory never answers.
    task automatic run_access(input int lat, input logic [31:0] rdat, output int w);
        int n;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_wdata;
        logic [3:0]        e_wstrb;
        logic              e_ack;
        logic [31:0]       e_rd;
        // IDLE cycle: nothing active, stray mem_ready ignored
        @(negedge clk);
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        #1;
        chk("idle_mem_req", 64'(mem_req), 64'd0);
        chk("idle_if_ack", 64'(if_ack), 64'd0);
        chk("idle_ls_ack", 64'(ls_ack), 64'd0);
        mem_ready = 1'b0;
        // round-robin model
        if (if_req && ls_req) w = m_last_ls ? 1 : 2;
        else if (ls_req)      w = 2;
        else                  w = 1;
        if (w == 2) begin
            e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata; e_wstrb = ls_wstrb;
        end else begin
            e_we = 1'b0; e_addr = if_addr; e_wdata = 32'd0; e_wstrb = 4'd0;
        end
        n = (lat <= TO) ? lat : TO;
        @(posedge clk);
        #1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            mem_ready = (c == lat);
            mem_rdata = (c == lat) ? rdat : $urandom;
            #1;
            e_ack = (c == n);
            e_rd  = (c == lat && !(w == 2 && e_we)) ? rdat : 32'd0;
            chk("busy_mem_req", 64'(mem_req), 64'd1);
            chk("mem_we", 64'(mem_we), 64'(e_we));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
            if (w == 2) begin
                chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
                chk("ls_ack", 64'(ls_ack), 64'(e_ack));
                chk("if_ack_quiet", 64'(if_ack), 64'd0);
                if (e_ack) begin
                    chk("ls_err", 64'(ls_err), 64'(lat > TO));
                    chk("ls_rdata", 64'(ls_rdata), 64'(e_rd));
                end
            end else begin
                chk("if_ack", 64'(if_ack), 64'(e_ack));
                chk("ls_ack_quiet", 64'(ls_ack), 64'd0);
                if (e_ack) begin
                    chk("if_err", 64'(if_err), 64'(lat > TO));
                    chk("if_rdata", 64'(if_rdata), 64'(e_rd));
                end
            end
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        if (w == 2) ls_req = 1'b0; else if_req = 1'b0;
        m_last_ls = (w == 2);
        $display("access %s lat=%0d addr=%h", (w == 2) ? "LS" : "IF", lat, e_addr);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        // reset state with noisy inputs
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_if_ack", 64'(if_ack), 64'd0);
        chk("rst_ls_ack", 64'(ls_ack), 64'd0);
        mem_ready = 1'b0;
        // both requests together after reset: LSU first, then fetch
        @(posedge clk); #1;
        rst_n = 1'b1;
        new_if(); new_ls();
        run_access(2, $urandom, who);
        chk("first_contention_ls", 64'(mem_addr), 64'(ls_addr));
        run_access(3, $urandom, who);
        // fetch alone, addr 0x100, ready in 3rd cycle
        if_req = 1'b1; if_addr = 24'h000100;
        run_access(3, 32'hDEADBEEF, who);
        // store 0x40
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 24'h000040;
        ls_wdata = 32'h12345678; ls_wstrb = 4'h3;
        run_access(2, 32'hCAFEF00D, who);
        // fetch timeout, then ready exactly at limit
        new_if();
        run_access(TO + 1, $urandom, who);
        new_ls();
        run_access(TO, $urandom, who);
        // reset during an LSU access, fetch pending
        @(negedge clk); rst_n = 1'b0; m_last_ls = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        new_if(); new_ls(); ls_we = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
        chk("pre_rst_mem_addr", 64'(mem_addr), 64'(ls_addr));
        mem_ready = 1'b1;
        rst_n = 1'b0; #1;
        chk("async_rst_mem_req", 64'(mem_req), 64'd0);
        chk("async_rst_ls_ack", 64'(ls_ack), 64'd0);
        chk("async_rst_mem_addr", 64'(mem_addr), 64'd0);
        ls_req = 1'b0; mem_ready = 1'b0; m_last_ls = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_access(2, $urandom, who);
        chk("post_rst_fetch_addr", 64'(mem_addr), 64'(if_addr));
        // continuous traffic on both ports: strict alternation
        prev_who = (m_last_ls) ? 2 : 1;
        for (int k = 0; k < 20; k++) begin
            if (!if_req) new_if();
            if (!ls_req) new_ls();
            run_access(int'($urandom_range(1, TO + 1)), $urandom, who);
            chk("alternate_addr", 64'(mem_addr), (prev_who == 2) ? 64'(if_addr) : 64'(ls_addr));
            prev_who = who;
        end
        // random mixed traffic
        for (int k = 0; k < 16; k++) begin
            if (!if_req && ($urandom_range(0, 1) == 1)) new_if();
            if (!ls_req && ($urandom_range(0, 1) == 1)) new_ls();
            if (!if_req && !ls_req) new_if();
            run_access(int'($urandom_range(1, TO + 1)), $urandom, who);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tinyrv_mem_arb.md
TINYRV_MEM_ARB -- requirements
Module: tinyrv_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 24, byte address width of all ports.
REQ-002 Parameter TO_CYC, default 255, maximum cycles a memory access may wait for mem_ready before abort, range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch request; held with if_addr until if_ack.
REQ-006 if_addr  input  ADDR_W  fetch byte address, word-aligned.
REQ-007 if_rdata  output  32  fetch read data, valid only while if_ack=1.
REQ-008 if_ack  output  1  fetch completion, one-cycle pulse.
REQ-009 if_err  output  1  fetch timed out, coincident with if_ack.
REQ-010 ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata/ls_wstrb until ls_ack.
REQ-011 ls_we  input  1  1 = store, 0 = load.
REQ-012 ls_addr  input  ADDR_W  load/store byte address.
REQ-013 ls_wdata  input  32  store data.
REQ-014 ls_wstrb  input  4  store byte enables.
REQ-015 ls_rdata  output  32  load data, valid only while ls_ack=1.
REQ-016 ls_ack  output  1  load/store completion, one-cycle pulse.
REQ-017 ls_err  output  1  load/store timed out, coincident with ls_ack.
REQ-018 mem_req  output  1  memory access active; held until mem_ready or timeout.
REQ-019 mem_we, mem_addr[ADDR_W], mem_wdata[32], mem_wstrb[4]  output  access fields, registered, stable while mem_req=1.
REQ-020 mem_rdata  input  32  read data, sampled when mem_ready=1.
REQ-021 mem_ready  input  1  one-cycle completion from memory; ignored while mem_req=0.

Function
REQ-022 FSM states IDLE, BUSY_IF, BUSY_LS.
REQ-023 IDLE, only if_req: next state BUSY_IF, latch if_addr, mem_we=0, mem_wstrb=0, mem_req=1 from next cycle.
REQ-024 IDLE, only ls_req: next state BUSY_LS, latch ls_* fields onto mem_*, mem_req=1 from next cycle.
REQ-025 IDLE, both requests: grant the requester not served last (round-robin flag last_ls); last_ls resets to 0, so first contention grants LSU.
REQ-026 last_ls updates on each grant: 1 on LSU grant, 0 on fetch grant.
REQ-027 BUSY_x with mem_ready=1: x_ack=1 combinationally same cycle, x_rdata = mem_rdata (load/fetch) else 0, x_err=0, mem_req drops and state returns to IDLE next edge.
REQ-028 A requester may drop req on the ack edge; req high in IDLE is always a new request; minimum spacing between grants is one IDLE cycle.
REQ-029 Timeout counter clears on each grant, increments each BUSY cycle without mem_ready; when count reaches TO_CYC: x_ack=1, x_err=1, x_rdata=0, mem_req drops, state IDLE.
REQ-030 mem_ready and timeout in same cycle: mem_ready wins, err=0.
REQ-031 Non-granted request held during BUSY is not acked and is served at next IDLE.
REQ-032 if_ack and ls_ack never both 1; mem_req never 1 in IDLE.
REQ-033 ena not used; gating occurs at top level.

Reset
REQ-034 rst_n=0 immediately forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, counter=0, last_ls=0; acks/errs 0.
REQ-035 Reset mid-access abandons it with no ack; first edge after release may grant.

Structure
REQ-036 State encoding enum and TO_CYC default live in shared package tinyrv_pkg.
REQ-037 Single flat module; no sub-module.

Verification
REQ-038 Fetch alone, addr 0x000100, mem_ready after 3 cycles with 0xDEADBEEF -> mem_req high 3 cycles, if_ack pulse with if_rdata=0xDEADBEEF.
REQ-039 if_req and ls_req both rise in same cycle after reset, both held -> LSU served first, fetch granted in cycle after LSU's IDLE cycle.
REQ-040 Store ls_addr 0x000040, wdata 0x12345678, wstrb 0x3 -> mem_we=1, fields match, ls_ack on mem_ready, ls_rdata=0.
REQ-041 Fetch with mem_ready never asserted, TO_CYC=4 -> if_ack=1, if_err=1 at 4th BUSY cycle, mem_req low next cycle.
REQ-042 rst_n low during BUSY_LS -> mem_req=0 asynchronously, no ls_ack, pending fetch granted after release.
REQ-043 Continuous both-request traffic 20 accesses -> strict alternation, no simultaneous acks.
